// File: rtl/trsq8_prom_pkg.sv
// Shared constants and encodings for the program-ROM fetch arbiter.
package trsq8_prom_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 15;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

endpackage

// File: rtl/prom_arb_fairness.sv
// Starvation counter: counts contested CPU wins and forces a debug grant
// once STARVE_LIMIT is reached (STARVE_LIMIT = 0 disables forcing).
module prom_arb_fairness #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_contested,
    input  logic i_cpu_win,
    input  logic i_dbg_win,
    output logic o_force_dbg
);
    import trsq8_prom_pkg::*;

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_dbg_win) begin
            r_cnt <= '0;
        end else if (i_contested && i_cpu_win && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_force_dbg = (STARVE_LIMIT != 0) && (r_cnt == LIMIT);

endmodule

// File: rtl/prom_fetch_arbiter.sv
// Arbitrates the single combinational program ROM between CPU fetch and debug
// reads, with a halt handshake. Define PROM_ARB_STATS_EN for grant counters.
module prom_fetch_arbiter #(
    parameter int ADDR_W       = trsq8_prom_pkg::ADDR_W,
    parameter int DATA_W       = trsq8_prom_pkg::DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK_ip,
    input  logic              RST_ip,
    input  logic              CPU_REQ_ip,
    input  logic [ADDR_W-1:0] CPU_ADDR_ip,
    output logic              CPU_GNT_op,
    output logic              CPU_VALID_op,
    output logic [DATA_W-1:0] CPU_DATA_op,
    input  logic              DBG_REQ_ip,
    input  logic [ADDR_W-1:0] DBG_ADDR_ip,
    output logic              DBG_GNT_op,
    output logic              DBG_VALID_op,
    output logic [DATA_W-1:0] DBG_DATA_op,
    input  logic              HALT_ip,
    output logic              HALTED_op,
    output logic [ADDR_W-1:0] PROM_ADDR_op,
    input  logic [DATA_W-1:0] PROM_DATA_ip
`ifdef PROM_ARB_STATS_EN
   ,output logic [15:0]       CPU_CNT_op,
    output logic [15:0]       DBG_CNT_op
`endif
);
    import trsq8_prom_pkg::*;

    halt_state_t       r_state, w_state_nxt;
    owner_t            w_owner;
    logic              w_cpu_elig, w_contested, w_force_dbg;
    logic              w_cpu_gnt, w_dbg_gnt;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_cpu_valid, r_dbg_valid;
    logic [DATA_W-1:0] r_cpu_data, r_dbg_data;

    always_ff @(posedge CLK_ip) begin
        if (RST_ip) r_state <= RUN;
        else        r_state <= w_state_nxt;
    end

    // Raising HALT in RUN blocks the CPU immediately; DRAIN covers the
    // return of a read granted just before the halt took effect.
    always_comb begin
        w_state_nxt = r_state;
        w_cpu_elig  = 1'b0;
        case (r_state)
            RUN: begin
                w_cpu_elig = !HALT_ip;
                if (HALT_ip) w_state_nxt = DRAIN;
            end
            DRAIN:   w_state_nxt = HALT_ip ? HALTED : RUN;
            HALTED:  if (!HALT_ip) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        w_owner     = OWN_NONE;
        w_contested = CPU_REQ_ip && DBG_REQ_ip && w_cpu_elig;
        if (!RST_ip) begin
            if (CPU_REQ_ip && w_cpu_elig && !(DBG_REQ_ip && w_force_dbg))
                w_owner = OWN_CPU;
            else if (DBG_REQ_ip)
                w_owner = OWN_DBG;
        end
        w_cpu_gnt = (w_owner == OWN_CPU);
        w_dbg_gnt = (w_owner == OWN_DBG);
    end

    always_comb begin
        case (w_owner)
            OWN_CPU: PROM_ADDR_op = CPU_ADDR_ip;
            OWN_DBG: PROM_ADDR_op = DBG_ADDR_ip;
            default: PROM_ADDR_op = r_last_addr;
        endcase
    end

    prom_arb_fairness #(.STARVE_LIMIT(STARVE_LIMIT)) u_fair (
        .i_clk       (CLK_ip),
        .i_rst       (RST_ip),
        .i_contested (w_contested),
        .i_cpu_win   (w_cpu_gnt),
        .i_dbg_win   (w_dbg_gnt),
        .o_force_dbg (w_force_dbg)
    );

    always_ff @(posedge CLK_ip) begin
        if (RST_ip) begin
            r_last_addr <= '0;
            r_cpu_valid <= 1'b0;
            r_dbg_valid <= 1'b0;
            r_cpu_data  <= '0;
            r_dbg_data  <= '0;
        end else begin
            r_last_addr <= PROM_ADDR_op;
            r_cpu_valid <= w_cpu_gnt;
            r_dbg_valid <= w_dbg_gnt;
            if (w_cpu_gnt) r_cpu_data <= PROM_DATA_ip;
            if (w_dbg_gnt) r_dbg_data <= PROM_DATA_ip;
        end
    end

    assign CPU_GNT_op   = w_cpu_gnt;
    assign DBG_GNT_op   = w_dbg_gnt;
    // A valid owed from before a reset is suppressed during the reset cycle.
    assign CPU_VALID_op = r_cpu_valid && !RST_ip;
    assign DBG_VALID_op = r_dbg_valid && !RST_ip;
    assign CPU_DATA_op  = r_cpu_data;
    assign DBG_DATA_op  = r_dbg_data;
    assign HALTED_op    = (r_state == HALTED);

`ifdef PROM_ARB_STATS_EN
    logic [15:0] r_cpu_cnt, r_dbg_cnt;

    always_ff @(posedge CLK_ip) begin
        if (RST_ip) begin
            r_cpu_cnt <= '0;
            r_dbg_cnt <= '0;
        end else begin
            if (w_cpu_gnt && (r_cpu_cnt != 16'hFFFF)) r_cpu_cnt <= r_cpu_cnt + 16'd1;
            if (w_dbg_gnt && (r_dbg_cnt != 16'hFFFF)) r_dbg_cnt <= r_dbg_cnt + 16'd1;
        end
    end

    assign CPU_CNT_op = r_cpu_cnt;
    assign DBG_CNT_op = r_dbg_cnt;
`endif

endmodule

// File: tb/tb_prom_fetch_arbiter.sv
// Self-checking bench for prom_fetch_arbiter: directed scenarios plus random
// traffic, all compared every cycle against a rule-level reference model.
module tb_prom_fetch_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        CLK_ip = 1'b0;
    logic        RST_ip = 1'b1;
    logic        CPU_REQ_ip = 1'b0;
    logic [12:0] CPU_ADDR_ip = '0;
    logic        CPU_GNT_op, CPU_VALID_op;
    logic [14:0] CPU_DATA_op;
    logic        DBG_REQ_ip = 1'b0;
    logic [12:0] DBG_ADDR_ip = '0;
    logic        DBG_GNT_op, DBG_VALID_op;
    logic [14:0] DBG_DATA_op;
    logic        HALT_ip = 1'b0;
    logic        HALTED_op;
    logic [12:0] PROM_ADDR_op;
    logic [14:0] PROM_DATA_ip;
`ifdef PROM_ARB_STATS_EN
    logic [15:0] CPU_CNT_op, DBG_CNT_op;
`endif

    int checks = 0;
    int failures = 0;

    always #5 CLK_ip = ~CLK_ip;

    function automatic logic [14:0] prom_f(input logic [12:0] a);
        if (a == 13'd0)  return 15'b010111000000001;
        if (a == 13'd24) return 15'b000000100000000;
        return {2'b10, a} ^ {a[6:0], a[12:5]};
    endfunction

    assign PROM_DATA_ip = prom_f(PROM_ADDR_op);

    prom_fetch_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .CLK_ip       (CLK_ip),
        .RST_ip       (RST_ip),
        .CPU_REQ_ip   (CPU_REQ_ip),
        .CPU_ADDR_ip  (CPU_ADDR_ip),
        .CPU_GNT_op   (CPU_GNT_op),
        .CPU_VALID_op (CPU_VALID_op),
        .CPU_DATA_op  (CPU_DATA_op),
        .DBG_REQ_ip   (DBG_REQ_ip),
        .DBG_ADDR_ip  (DBG_ADDR_ip),
        .DBG_GNT_op   (DBG_GNT_op),
        .DBG_VALID_op (DBG_VALID_op),
        .DBG_DATA_op  (DBG_DATA_op),
        .HALT_ip      (HALT_ip),
        .HALTED_op    (HALTED_op),
        .PROM_ADDR_op (PROM_ADDR_op),
        .PROM_DATA_ip (PROM_DATA_ip)
`ifdef PROM_ARB_STATS_EN
       ,.CPU_CNT_op   (CPU_CNT_op),
        .DBG_CNT_op   (DBG_CNT_op)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK_ip);
        #1;
    endtask

    // Reference model: phase 0=running, 1=draining, 2=halted.
    bit          m_known = 0;
    int          m_ph, m_starve, m_cc, m_dc;
    logic [12:0] m_last;
    logic        m_cv, m_dv;
    logic [14:0] m_cd, m_dd;
    logic        e_cg, e_dg, cpu_ok;
    logic [12:0] e_a;

    always @(negedge CLK_ip) begin
        if (RST_ip) begin
            chk("rst_cpu_gnt",   CPU_GNT_op,   0);
            chk("rst_dbg_gnt",   DBG_GNT_op,   0);
            chk("rst_cpu_valid", CPU_VALID_op, 0);
            chk("rst_dbg_valid", DBG_VALID_op, 0);
            m_known = 1; m_ph = 0; m_starve = 0; m_last = '0;
            m_cv = 0; m_dv = 0; m_cd = '0; m_dd = '0; m_cc = 0; m_dc = 0;
        end else if (m_known) begin
            cpu_ok = (m_ph == 0) && !HALT_ip;
            e_cg = CPU_REQ_ip && cpu_ok &&
                   !(DBG_REQ_ip && STARVE_LIMIT != 0 && m_starve == STARVE_LIMIT);
            e_dg = DBG_REQ_ip && !e_cg;
            e_a  = e_cg ? CPU_ADDR_ip : (e_dg ? DBG_ADDR_ip : m_last);
            chk("m_cpu_gnt",   CPU_GNT_op,   e_cg);
            chk("m_dbg_gnt",   DBG_GNT_op,   e_dg);
            chk("m_prom_addr", PROM_ADDR_op, e_a);
            chk("m_cpu_valid", CPU_VALID_op, m_cv);
            chk("m_dbg_valid", DBG_VALID_op, m_dv);
            chk("m_cpu_data",  CPU_DATA_op,  m_cd);
            chk("m_dbg_data",  DBG_DATA_op,  m_dd);
            chk("m_halted",    HALTED_op,    m_ph == 2);
`ifdef PROM_ARB_STATS_EN
            chk("m_cpu_cnt",   CPU_CNT_op,   m_cc);
            chk("m_dbg_cnt",   DBG_CNT_op,   m_dc);
`endif
            m_cv = e_cg; m_dv = e_dg; m_last = e_a;
            if (e_cg) m_cd = prom_f(CPU_ADDR_ip);
            if (e_dg) m_dd = prom_f(DBG_ADDR_ip);
            if (e_dg) m_starve = 0;
            else if (e_cg && DBG_REQ_ip && m_starve < STARVE_LIMIT) m_starve++;
            if (e_cg && m_cc < 65535) m_cc++;
            if (e_dg && m_dc < 65535) m_dc++;
            case (m_ph)
                0:       m_ph = HALT_ip ? 1 : 0;
                1:       m_ph = HALT_ip ? 2 : 0;
                default: m_ph = HALT_ip ? 2 : 0;
            endcase
        end
    end

    logic [12:0] ca;
    logic        pc, pd;

    initial begin
        // Reset: a request during reset must not be granted
        tick(); CPU_REQ_ip = 1; CPU_ADDR_ip = 13'd5; #2;
        chk("rst_gnt_blocked", CPU_GNT_op, 0);
        tick(); RST_ip = 0; CPU_REQ_ip = 0; #2;
        chk("post_rst_cpu_valid", CPU_VALID_op, 0);
        chk("post_rst_dbg_valid", DBG_VALID_op, 0);
        chk("post_rst_cpu_data",  CPU_DATA_op,  0);
        chk("post_rst_dbg_data",  DBG_DATA_op,  0);
        chk("post_rst_halted",    HALTED_op,    0);
        chk("post_rst_prom_addr", PROM_ADDR_op, 0);

        // CPU-only stream, addresses 0,1,2
        tick(); CPU_REQ_ip = 1; CPU_ADDR_ip = 13'd0; #2;
        chk("cpu0_gnt", CPU_GNT_op, 1);
        tick(); CPU_ADDR_ip = 13'd1; #2;
        chk("cpu1_gnt", CPU_GNT_op, 1);
        chk("cpu0_valid", CPU_VALID_op, 1);
        chk("cpu0_data", CPU_DATA_op, 15'b010111000000001);
        tick(); CPU_ADDR_ip = 13'd2; #2;
        chk("cpu2_gnt", CPU_GNT_op, 1);
        chk("cpu1_valid", CPU_VALID_op, 1);
        tick(); CPU_REQ_ip = 0; #2;
        chk("cpu2_valid", CPU_VALID_op, 1);
        chk("cpu_idle_gnt", CPU_GNT_op, 0);
        tick(); #2;
        chk("cpu_valid_pulse_end", CPU_VALID_op, 0);

        // Contested: CPU x4 then DBG, repeating
        ca = 13'd100;
        for (int i = 0; i < 10; i++) begin
            tick(); CPU_REQ_ip = 1; CPU_ADDR_ip = ca; DBG_REQ_ip = 1; DBG_ADDR_ip = 13'd24; #2;
            chk("pat_cpu_gnt", CPU_GNT_op, (i % 5) != 4);
            chk("pat_dbg_gnt", DBG_GNT_op, (i % 5) == 4);
            if (i == 5) chk("dbg24_data", {DBG_VALID_op, DBG_DATA_op}, {1'b1, 15'b000000100000000});
            if (CPU_GNT_op) ca = ca + 13'd1;
        end
        tick(); CPU_REQ_ip = 0; DBG_REQ_ip = 0;

        // Halt during CPU streaming
        tick(); CPU_REQ_ip = 1; CPU_ADDR_ip = 13'd200; #2;
        tick(); CPU_ADDR_ip = 13'd201; #2;
        tick(); CPU_ADDR_ip = 13'd202; HALT_ip = 1; #2;
        chk("halt_cpu_gnt0", CPU_GNT_op, 0);
        chk("halt_prev_valid", CPU_VALID_op, 1);
        chk("halt_not_yet", HALTED_op, 0);
        tick(); #2;
        chk("drain_halted0", HALTED_op, 0);
        chk("drain_cpu_gnt0", CPU_GNT_op, 0);
        tick(); DBG_REQ_ip = 1; DBG_ADDR_ip = 13'd24; #2;
        chk("halted_at_2", HALTED_op, 1);
        chk("halted_cpu_gnt0", CPU_GNT_op, 0);
        chk("halted_dbg_gnt", DBG_GNT_op, 1);
        tick(); DBG_REQ_ip = 0; #2;
        chk("halted_dbg_data", {DBG_VALID_op, DBG_DATA_op}, {1'b1, 15'b000000100000000});
        tick(); HALT_ip = 0; #2;
        chk("unhalt_still_halted", HALTED_op, 1);
        chk("unhalt_cpu_gnt0", CPU_GNT_op, 0);
        tick(); #2;
        chk("unhalt_halted0", HALTED_op, 0);
        chk("unhalt_cpu_gnt", CPU_GNT_op, 1);
        tick(); CPU_REQ_ip = 0;

        // Reset mid-operation: starve counter and in-flight valid discarded
        ca = 13'd300;
        for (int i = 0; i < 3; i++) begin
            tick(); CPU_REQ_ip = 1; CPU_ADDR_ip = ca; DBG_REQ_ip = 1; DBG_ADDR_ip = 13'd30; #2;
            if (CPU_GNT_op) ca = ca + 13'd1;
        end
        tick(); RST_ip = 1; #2;
        chk("midrst_cpu_valid", CPU_VALID_op, 0);
        tick(); RST_ip = 0; CPU_REQ_ip = 0; DBG_REQ_ip = 0; #2;
        chk("midrst_post_valid", CPU_VALID_op, 0);
        chk("midrst_cpu_data", CPU_DATA_op, 0);
        chk("midrst_prom_addr", PROM_ADDR_op, 0);
        for (int i = 0; i < 5; i++) begin
            tick(); CPU_REQ_ip = 1; CPU_ADDR_ip = ca; DBG_REQ_ip = 1; DBG_ADDR_ip = 13'd40; #2;
            chk("midrst_pat_cpu", CPU_GNT_op, i != 4);
            chk("midrst_pat_dbg", DBG_GNT_op, i == 4);
            if (CPU_GNT_op) ca = ca + 13'd1;
        end
        tick(); CPU_REQ_ip = 0; DBG_REQ_ip = 0;

`ifdef PROM_ARB_STATS_EN
        tick(); RST_ip = 1;
        tick(); RST_ip = 0;
        for (int i = 0; i < 10; i++) begin
            tick(); CPU_REQ_ip = 1; CPU_ADDR_ip = 13'(500 + i);
        end
        tick(); CPU_REQ_ip = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); DBG_REQ_ip = 1; DBG_ADDR_ip = 13'(600 + i);
        end
        tick(); DBG_REQ_ip = 0; #2;
        chk("stats_cpu10", CPU_CNT_op, 10);
        chk("stats_dbg3",  DBG_CNT_op, 3);
        tick(); RST_ip = 1;
        tick(); RST_ip = 0; #2;
        chk("stats_cpu_clr", CPU_CNT_op, 0);
        chk("stats_dbg_clr", DBG_CNT_op, 0);
`endif

        // Random traffic obeying the hold-until-granted protocol
        pc = 1; pd = 1;
        for (int i = 0; i < 800; i++) begin
            tick();
            RST_ip = ($urandom_range(0, 99) == 0);
            if (!CPU_REQ_ip || pc || RST_ip) begin
                CPU_REQ_ip  = ($urandom_range(0, 3) != 0);
                CPU_ADDR_ip = 13'($urandom);
            end
            if (!DBG_REQ_ip || pd || RST_ip) begin
                DBG_REQ_ip  = ($urandom_range(0, 1) != 0);
                DBG_ADDR_ip = ($urandom_range(0, 7) == 0) ? 13'd24 : 13'($urandom);
            end
            if ($urandom_range(0, 15) == 0) HALT_ip = ~HALT_ip;
            #2;
            pc = CPU_GNT_op; pd = DBG_GNT_op;
        end
        tick(); RST_ip = 0; CPU_REQ_ip = 0; DBG_REQ_ip = 0; HALT_ip = 0;
        tick(); tick(); #2;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
